// File: rtl/id_ex_operand_stage_if.sv
// Bundles every signal between the ID/EX operand stage and its neighbours.
//   Decode side   : D_* fields of the instruction leaving decode, Flush from branch resolution
//   Forward paths : M_* (EX/MEM result) and W_* (MEM/WB writeback)
//   Stage outputs : Stall to IF/ID, ALU control/operands, E_* attributes of the EX slot
// master = surrounding pipeline, slave = id_ex_operand_stage.
interface id_ex_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              D_Valid;
    logic [2:0]        D_ALUCtrl;
    logic [REG_AW-1:0] D_RsAddr;
    logic [REG_AW-1:0] D_RtAddr;
    logic [DATA_W-1:0] D_RsData;
    logic [DATA_W-1:0] D_RtData;
    logic [DATA_W-1:0] D_Imm;
    logic              D_UseRs;
    logic              D_UseRt;
    logic              D_UseImm;
    logic              D_RegWrite;
    logic [REG_AW-1:0] D_WrAddr;
    logic              D_MemRead;
    logic              Flush;
    logic              M_RegWrite;
    logic [REG_AW-1:0] M_WrAddr;
    logic [DATA_W-1:0] M_Result;
    logic              W_RegWrite;
    logic [REG_AW-1:0] W_WrAddr;
    logic [DATA_W-1:0] W_Data;
    logic              Stall;
    logic [2:0]        ALUControl;
    logic [DATA_W-1:0] ALUSrc1;
    logic [DATA_W-1:0] ALUSrc2;
    logic              E_Valid;
    logic              E_RegWrite;
    logic              E_MemRead;
    logic [REG_AW-1:0] E_WrAddr;
    logic [DATA_W-1:0] E_StoreData;

    modport master (
        output D_Valid, D_ALUCtrl, D_RsAddr, D_RtAddr, D_RsData, D_RtData, D_Imm,
               D_UseRs, D_UseRt, D_UseImm, D_RegWrite, D_WrAddr, D_MemRead, Flush,
               M_RegWrite, M_WrAddr, M_Result, W_RegWrite, W_WrAddr, W_Data,
        input  Stall, ALUControl, ALUSrc1, ALUSrc2, E_Valid, E_RegWrite, E_MemRead,
               E_WrAddr, E_StoreData
    );

    modport slave (
        input  D_Valid, D_ALUCtrl, D_RsAddr, D_RtAddr, D_RsData, D_RtData, D_Imm,
               D_UseRs, D_UseRt, D_UseImm, D_RegWrite, D_WrAddr, D_MemRead, Flush,
               M_RegWrite, M_WrAddr, M_Result, W_RegWrite, W_WrAddr, W_Data,
        output Stall, ALUControl, ALUSrc1, ALUSrc2, E_Valid, E_RegWrite, E_MemRead,
               E_WrAddr, E_StoreData
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection,
// sitting directly in front of the ALU.
//   clk  : all state on the rising edge
//   rst  : synchronous, active-high; clears the EX slot
//   bus  : id_ex_operand_stage_if.slave (decode inputs, M/W forward paths, ALU drive, Stall)
// Decode -> ALU inputs is exactly one cycle; forwarding is purely combinational.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_operand_stage_if.slave  bus
);
    localparam logic [2:0] ALU_NOP = 3'd0;

    // EX slot
    logic              e_valid;
    logic [2:0]        e_ctrl;
    logic [REG_AW-1:0] e_rs_addr;
    logic [REG_AW-1:0] e_rt_addr;
    logic [DATA_W-1:0] e_rs_data;
    logic [DATA_W-1:0] e_rt_data;
    logic [DATA_W-1:0] e_imm;
    logic              e_use_imm;
    logic              e_regwrite;
    logic              e_memread;
    logic [REG_AW-1:0] e_wraddr;

    logic              stall;
    logic              e_regwrite_g;
    logic              e_memread_g;
    logic              w_hit_rs;
    logic              w_hit_rt;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    assign e_regwrite_g = e_valid & e_regwrite;
    assign e_memread_g  = e_valid & e_memread;

    // Load in EX whose destination is read by the instruction in decode.
    // The bubble clears e_memread_g, so each hazard stalls exactly once.
    assign stall = ~rst & ~bus.Flush & bus.D_Valid & e_memread_g & e_regwrite_g &
                   (e_wraddr != '0) &
                   ((bus.D_UseRs & (bus.D_RsAddr == e_wraddr)) |
                    (bus.D_UseRt & (bus.D_RtAddr == e_wraddr)));

    // Writeback lands in the register file on the same edge we capture,
    // so take the W value directly instead of the stale read.
    assign w_hit_rs = bus.W_RegWrite & (bus.W_WrAddr != '0) & (bus.W_WrAddr == bus.D_RsAddr);
    assign w_hit_rt = bus.W_RegWrite & (bus.W_WrAddr != '0) & (bus.W_WrAddr == bus.D_RtAddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid    <= 1'b0;
            e_ctrl     <= ALU_NOP;
            e_rs_addr  <= '0;
            e_rt_addr  <= '0;
            e_rs_data  <= '0;
            e_rt_data  <= '0;
            e_imm      <= '0;
            e_use_imm  <= 1'b0;
            e_regwrite <= 1'b0;
            e_memread  <= 1'b0;
            e_wraddr   <= '0;
        end else begin
            // Flush or stall turns the entering slot into a bubble; payload still loads.
            e_valid    <= bus.D_Valid & ~bus.Flush & ~stall;
            e_ctrl     <= bus.D_ALUCtrl;
            e_rs_addr  <= bus.D_RsAddr;
            e_rt_addr  <= bus.D_RtAddr;
            e_rs_data  <= w_hit_rs ? bus.W_Data : bus.D_RsData;
            e_rt_data  <= w_hit_rt ? bus.W_Data : bus.D_RtData;
            e_imm      <= bus.D_Imm;
            e_use_imm  <= bus.D_UseImm;
            e_regwrite <= bus.D_RegWrite;
            e_memread  <= bus.D_MemRead;
            e_wraddr   <= bus.D_WrAddr;
        end
    end

    // EX forwarding: youngest producer (M) wins over W; r0 never forwarded.
    always_comb begin
        rs_fwd = e_rs_data;
        if (bus.M_RegWrite && bus.M_WrAddr != '0 && bus.M_WrAddr == e_rs_addr)
            rs_fwd = bus.M_Result;
        else if (bus.W_RegWrite && bus.W_WrAddr != '0 && bus.W_WrAddr == e_rs_addr)
            rs_fwd = bus.W_Data;

        rt_fwd = e_rt_data;
        if (bus.M_RegWrite && bus.M_WrAddr != '0 && bus.M_WrAddr == e_rt_addr)
            rt_fwd = bus.M_Result;
        else if (bus.W_RegWrite && bus.W_WrAddr != '0 && bus.W_WrAddr == e_rt_addr)
            rt_fwd = bus.W_Data;
    end

    assign bus.Stall       = stall;
    assign bus.ALUControl  = e_valid ? e_ctrl : ALU_NOP;
    assign bus.ALUSrc1     = rs_fwd;
    assign bus.ALUSrc2     = e_use_imm ? e_imm : rt_fwd;
    assign bus.E_Valid     = e_valid;
    assign bus.E_RegWrite  = e_regwrite_g;
    assign bus.E_MemRead   = e_memread_g;
    assign bus.E_WrAddr    = e_wraddr;
    assign bus.E_StoreData = rt_fwd;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.D_Valid = 0; bus.D_ALUCtrl = ALU_NOP; bus.D_RsAddr = 0; bus.D_RtAddr = 0;
        bus.D_RsData = 0; bus.D_RtData = 0; bus.D_Imm = 0; bus.D_UseRs = 0; bus.D_UseRt = 0;
        bus.D_UseImm = 0; bus.D_RegWrite = 0; bus.D_WrAddr = 0; bus.D_MemRead = 0;
        bus.Flush = 0; bus.M_RegWrite = 0; bus.M_WrAddr = 0; bus.M_Result = 0;
        bus.W_RegWrite = 0; bus.W_WrAddr = 0; bus.W_Data = 0;
    endtask

    // Decode slot: load ADD rs=1 -> rd=dst (address calc with immediate)
    task automatic drive_load(input logic [4:0] dst);
        clear_inputs();
        bus.D_Valid = 1; bus.D_ALUCtrl = ALU_ADD; bus.D_RsAddr = 5'd1; bus.D_RsData = 32'h100;
        bus.D_UseRs = 1; bus.D_UseImm = 1; bus.D_Imm = 32'h8;
        bus.D_RegWrite = 1; bus.D_WrAddr = dst; bus.D_MemRead = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        drive_load(5'd4);        // garbage on decode must not leak through reset
        tick();
        tick();
        #1;
        n_chk++; if (bus.ALUControl !== ALU_NOP) begin n_fail++; $display("FAIL reset_ctrl: got %0d want %0d", bus.ALUControl, ALU_NOP); end
        n_chk++; if (bus.ALUSrc1 !== 32'h0) begin n_fail++; $display("FAIL reset_src1: got %h want 0", bus.ALUSrc1); end
        n_chk++; if (bus.ALUSrc2 !== 32'h0) begin n_fail++; $display("FAIL reset_src2: got %h want 0", bus.ALUSrc2); end
        n_chk++; if (bus.E_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_evalid: got %b want 0", bus.E_Valid); end
        n_chk++; if (bus.E_StoreData !== 32'h0) begin n_fail++; $display("FAIL reset_store: got %h want 0", bus.E_StoreData); end
        n_chk++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.Stall); end
        clear_inputs();
        rst = 0;
        tick();
    endtask

    task automatic test_pass_through();
        clear_inputs();
        bus.D_Valid = 1; bus.D_ALUCtrl = ALU_ADD; bus.D_RsAddr = 5'd1; bus.D_RtAddr = 5'd2;
        bus.D_RsData = 32'd5; bus.D_RtData = 32'd7; bus.D_UseRs = 1; bus.D_UseRt = 1;
        bus.D_RegWrite = 1; bus.D_WrAddr = 5'd9;
        tick();
        clear_inputs();
        #1;
        n_chk++; if (bus.ALUControl !== ALU_ADD) begin n_fail++; $display("FAIL pass_ctrl: got %0d want %0d", bus.ALUControl, ALU_ADD); end
        n_chk++; if (bus.ALUSrc1 !== 32'd5) begin n_fail++; $display("FAIL pass_src1: got %h want 5", bus.ALUSrc1); end
        n_chk++; if (bus.ALUSrc2 !== 32'd7) begin n_fail++; $display("FAIL pass_src2: got %h want 7", bus.ALUSrc2); end
        n_chk++; if (bus.E_Valid !== 1'b1 || bus.E_RegWrite !== 1'b1 || bus.E_WrAddr !== 5'd9) begin
            n_fail++; $display("FAIL pass_eattr: got v=%b rw=%b wa=%0d want v=1 rw=1 wa=9", bus.E_Valid, bus.E_RegWrite, bus.E_WrAddr); end
    endtask

    task automatic test_priority_r0();
        clear_inputs();
        bus.D_Valid = 1; bus.D_ALUCtrl = ALU_ADD; bus.D_RsAddr = 5'd3; bus.D_RsData = 32'hAA; bus.D_UseRs = 1;
        tick();
        clear_inputs();
        bus.M_RegWrite = 1; bus.M_WrAddr = 5'd3; bus.M_Result = 32'h11;
        bus.W_RegWrite = 1; bus.W_WrAddr = 5'd3; bus.W_Data = 32'h22;
        #1;
        n_chk++; if (bus.ALUSrc1 !== 32'h11) begin n_fail++; $display("FAIL prio_m_over_w: got %h want 11", bus.ALUSrc1); end
        bus.M_RegWrite = 0;
        #1;
        n_chk++; if (bus.ALUSrc1 !== 32'h22) begin n_fail++; $display("FAIL prio_w_only: got %h want 22", bus.ALUSrc1); end
        bus.W_RegWrite = 0;
        #1;
        n_chk++; if (bus.ALUSrc1 !== 32'hAA) begin n_fail++; $display("FAIL prio_none: got %h want aa", bus.ALUSrc1); end
        // r0 source: writers targeting r0 are ignored
        bus.D_Valid = 1; bus.D_ALUCtrl = ALU_ADD; bus.D_RsAddr = 5'd0; bus.D_RsData = 32'h0; bus.D_UseRs = 1;
        tick();
        clear_inputs();
        bus.M_RegWrite = 1; bus.M_WrAddr = 5'd0; bus.M_Result = 32'h55;
        bus.W_RegWrite = 1; bus.W_WrAddr = 5'd0; bus.W_Data = 32'h66;
        #1;
        n_chk++; if (bus.ALUSrc1 !== 32'h0) begin n_fail++; $display("FAIL r0_no_fwd: got %h want 0", bus.ALUSrc1); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        drive_load(5'd4);
        tick();
        clear_inputs();
        bus.D_Valid = 1; bus.D_ALUCtrl = ALU_SUB; bus.D_RsAddr = 5'd2; bus.D_RsData = 32'd3;
        bus.D_RtAddr = 5'd4; bus.D_RtData = 32'hDEAD; bus.D_UseRs = 1; bus.D_UseRt = 1;
        bus.D_RegWrite = 1; bus.D_WrAddr = 5'd5;
        #1;
        n_chk++; if (bus.Stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", bus.Stall); end
        tick();                  // decode held, bubble enters EX
        #1;
        n_chk++; if (bus.E_Valid !== 1'b0 || bus.ALUControl !== ALU_NOP) begin
            n_fail++; $display("FAIL lu_bubble: got v=%b ctrl=%0d want v=0 ctrl=0", bus.E_Valid, bus.ALUControl); end
        n_chk++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %b want 0", bus.Stall); end
        tick();                  // held SUB enters EX; load result now forwarded
        bus.D_Valid = 0;
        bus.M_RegWrite = 1; bus.M_WrAddr = 5'd4; bus.M_Result = 32'h1234;
        #1;
        n_chk++; if (bus.E_Valid !== 1'b1 || bus.ALUControl !== ALU_SUB) begin
            n_fail++; $display("FAIL lu_sub_enter: got v=%b ctrl=%0d want v=1 ctrl=2", bus.E_Valid, bus.ALUControl); end
        n_chk++; if (bus.ALUSrc1 !== 32'd3) begin n_fail++; $display("FAIL lu_src1: got %h want 3", bus.ALUSrc1); end
        n_chk++; if (bus.ALUSrc2 !== 32'h1234) begin n_fail++; $display("FAIL lu_src2: got %h want 1234", bus.ALUSrc2); end
        clear_inputs();
    endtask

    task automatic test_flush_and_bypass();
        drive_load(5'd4);
        tick();
        clear_inputs();
        bus.D_Valid = 1; bus.D_ALUCtrl = ALU_SUB; bus.D_RtAddr = 5'd4; bus.D_UseRt = 1; bus.Flush = 1;
        #1;
        n_chk++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL flush_no_stall: got %b want 0", bus.Stall); end
        n_chk++; if (bus.E_Valid !== 1'b1 || bus.ALUControl !== ALU_ADD || bus.E_MemRead !== 1'b1) begin
            n_fail++; $display("FAIL flush_keeps_ex: got v=%b ctrl=%0d mr=%b want v=1 ctrl=1 mr=1", bus.E_Valid, bus.ALUControl, bus.E_MemRead); end
        // decode WB bypass rides on the next capture
        clear_inputs();
        bus.Flush = 1;
        tick();
        n_chk++; if (bus.E_Valid !== 1'b0 || bus.ALUControl !== ALU_NOP || bus.E_MemRead !== 1'b0) begin
            n_fail++; $display("FAIL flush_bubble: got v=%b ctrl=%0d mr=%b want v=0 ctrl=0 mr=0", bus.E_Valid, bus.ALUControl, bus.E_MemRead); end
        clear_inputs();
        bus.D_Valid = 1; bus.D_ALUCtrl = ALU_ADD; bus.D_RsAddr = 5'd6; bus.D_RsData = 32'd1; bus.D_UseRs = 1;
        bus.W_RegWrite = 1; bus.W_WrAddr = 5'd6; bus.W_Data = 32'd9;
        tick();
        clear_inputs();
        #1;
        n_chk++; if (bus.ALUSrc1 !== 32'd9) begin n_fail++; $display("FAIL wb_bypass: got %h want 9", bus.ALUSrc1); end
    endtask

    task automatic test_immediate();
        clear_inputs();
        bus.D_Valid = 1; bus.D_ALUCtrl = ALU_ADD; bus.D_RtAddr = 5'd5; bus.D_RtData = 32'h3;
        bus.D_UseRt = 1; bus.D_UseImm = 1; bus.D_Imm = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        bus.M_RegWrite = 1; bus.M_WrAddr = 5'd5; bus.M_Result = 32'h40;
        #1;
        n_chk++; if (bus.ALUSrc2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL imm_src2: got %h want fffffffc", bus.ALUSrc2); end
        n_chk++; if (bus.E_StoreData !== 32'h40) begin n_fail++; $display("FAIL imm_store: got %h want 40", bus.E_StoreData); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        drive_load(5'd4);
        tick();
        clear_inputs();
        bus.D_Valid = 1; bus.D_RsAddr = 5'd4; bus.D_UseRs = 1;
        rst = 1;
        #1;
        n_chk++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %b want 0", bus.Stall); end
        tick();
        clear_inputs();
        #1;
        n_chk++; if (bus.E_Valid !== 1'b0 || bus.ALUSrc1 !== 32'h0 || bus.E_WrAddr !== 5'd0) begin
            n_fail++; $display("FAIL rst_mid_clear: got v=%b src1=%h wa=%0d want 0/0/0", bus.E_Valid, bus.ALUSrc1, bus.E_WrAddr); end
        rst = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_priority_r0();
        test_load_use();
        test_flush_and_bypass();
        test_immediate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
